sym_timing_nco_ctrl: RTL and testbench

//  Symbol-timing NCO/scheduler driving the polyphase fractional-delay interpolator.

---
 rtl/msk_timing_pkg.sv | 60 ++++++
 rtl/sym_timing_nco_ctrl_if.sv | 28 ++
 rtl/sym_timing_nco_ctrl.sv | 158 +++++++++++++++
 tb/tb_sym_timing_nco_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_timing_pkg.sv
// Shared constants, types and helpers for the symbol-timing NCO.
// Contents:
//   OSF/TAPS_PPH/MU_W/PI_W/CTRL_W/MAX_ADJ/CNT_W  design parameters
//   M, ACC_W, SUM_W, INC_NOM                     accumulator modulus and widths
//   tim_state_e                                  IDLE / FILL / RUN
//   phase_t, mu_t, ctrl_t, sat_t                 datapath types
//   sat_ctrl()                                   clamp a correction to +/-MAX_ADJ
package msk_timing_pkg;

  localparam int OSF      = 20;
  localparam int TAPS_PPH = 5;
  localparam int MU_W     = 27;
  localparam int PI_W     = 5;
  localparam int CTRL_W   = 24;
  localparam int MAX_ADJ  = 2**20;
  localparam int CNT_W    = 16;

  localparam int FILL_LEN = OSF * TAPS_PPH;
  localparam int FILL_W   = $clog2(FILL_LEN);

  localparam longint unsigned M_VAL = 64'(OSF) << MU_W;
  localparam int ACC_W = $clog2(M_VAL);
  // One extra bit so acc + inc never overflows before the modulus compare.
  localparam int SUM_W = ACC_W + 1;
  localparam logic [SUM_W-1:0] M       = SUM_W'(M_VAL);
  localparam logic [SUM_W-1:0] INC_NOM = SUM_W'(64'd1 << MU_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } tim_state_e;

  typedef logic [PI_W-1:0]          phase_t;
  typedef logic [MU_W-1:0]          mu_t;
  typedef logic signed [CTRL_W-1:0] ctrl_t;

  typedef struct packed {
    ctrl_t value;
    logic  clamped;
  } sat_t;

  localparam ctrl_t ADJ_HI = ctrl_t'(MAX_ADJ);
  localparam ctrl_t ADJ_LO = ctrl_t'(-MAX_ADJ);

  function automatic sat_t sat_ctrl(input ctrl_t c);
    sat_t r;
    r.value   = c;
    r.clamped = 1'b0;
    if (c > ADJ_HI) begin
      r.value   = ADJ_HI;
      r.clamped = 1'b1;
    end else if (c < ADJ_LO) begin
      r.value   = ADJ_LO;
      r.clamped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sym_timing_nco_ctrl_if.sv
// Link between the timing NCO and the polyphase interpolator / loop filter.
// Signals:
//   ctrl_i       loop-filter rate correction (signed)
//   ctrl_valid_i capture strobe for ctrl_i
//   phase_int_o  integer sample phase 0..OSF-1
//   mu_o         fractional phase
//   sym_valid_o  one-clk symbol strobe
// Modports: master = NCO side, slave = interpolator / loop-filter side.
interface sym_timing_nco_ctrl_if;
  import msk_timing_pkg::*;

  ctrl_t  ctrl_i;
  logic   ctrl_valid_i;
  phase_t phase_int_o;
  mu_t    mu_o;
  logic   sym_valid_o;

  modport master (
    input  ctrl_i, ctrl_valid_i,
    output phase_int_o, mu_o, sym_valid_o
  );

  modport slave (
    output ctrl_i, ctrl_valid_i,
    input  phase_int_o, mu_o, sym_valid_o
  );

endinterface

// File: rtl/sym_timing_nco_ctrl.sv
// Symbol-timing NCO / scheduler for the polyphase fractional-delay interpolator.
// A modulo-M phase accumulator advances once per clk by (1<<MU_W) plus a
// saturated loop correction; each wrap issues a symbol strobe with the
// integer/fractional phase of the residue. A warm-up period of OSF*TAPS_PPH
// clocks holds off strobes until the interpolator delay line is full.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   enable_i       level; low forces IDLE
//   restart_i      pulse; zero the accumulator while running
//   interp         ctrl in / phase, mu, strobe out (master modport)
//   state_o        0=IDLE 1=FILL 2=RUN
//   sym_cnt_o      strobes since entering RUN, wraps
//   clamp_o        sticky: a captured correction was saturated
//
// state | meaning
// IDLE  | disabled; accumulator, fill and symbol counters held at zero
// FILL  | delay line warm-up, counts FILL_LEN clocks, no accumulation
// RUN   | accumulator advancing, strobe on each modulo-M wrap
module sym_timing_nco_ctrl
  import msk_timing_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_i,
  input  logic                  restart_i,
  sym_timing_nco_ctrl_if.master interp,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      sym_cnt_o,
  output logic                  clamp_o
);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_LEN - 1);

  tim_state_e         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               valid_q, valid_d;
  phase_t             phase_q, phase_d;
  mu_t                mu_q, mu_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               clamp_q, clamp_d;

  sat_t               cap;
  logic [SUM_W-1:0]   inc, sum;
  logic [ACC_W-1:0]   sum_red;
  logic               wrap;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      fill_q  <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      phase_q <= '0;
      mu_q    <= '0;
      cnt_q   <= '0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      phase_q <= phase_d;
      mu_q    <= mu_d;
      cnt_q   <= cnt_d;
      clamp_q <= clamp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = FILL;
        FILL:    if (fill_q == FILL_LAST) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // ctrl_q holds the already-saturated correction, so inc can never reach M
  // and at most one wrap happens per clk.
  always_comb begin
    inc     = INC_NOM + {{(SUM_W-CTRL_W){ctrl_q[CTRL_W-1]}}, ctrl_q};
    sum     = {1'b0, acc_q} + inc;
    wrap    = (sum >= M);
    sum_red = ACC_W'(sum - M);
  end

  always_comb begin
    cap     = sat_ctrl(interp.ctrl_i);
    acc_d   = acc_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    phase_d = phase_q;
    mu_d    = mu_q;
    ctrl_d  = interp.ctrl_valid_i ? cap.value : ctrl_q;
    // A saturating capture in the same clk as IDLE still sets the flag.
    clamp_d = ((state_q == IDLE) ? 1'b0 : clamp_q) |
              (interp.ctrl_valid_i & cap.clamped);

    if (!enable_i) begin
      acc_d  = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          acc_d  = '0;
          fill_d = '0;
          cnt_d  = '0;
        end
        FILL: begin
          acc_d = '0;
          if (fill_q == FILL_LAST) begin
            fill_d = '0;
            cnt_d  = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        RUN: begin
          if (restart_i) begin
            acc_d = '0;
          end else if (wrap) begin
            acc_d   = sum_red;
            valid_d = 1'b1;
            phase_d = sum_red[MU_W +: PI_W];
            mu_d    = sum_red[MU_W-1:0];
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
        end
        default: begin
          acc_d  = '0;
          fill_d = '0;
          cnt_d  = '0;
        end
      endcase
    end
  end

  assign interp.phase_int_o = phase_q;
  assign interp.mu_o        = mu_q;
  assign interp.sym_valid_o = valid_q;
  assign state_o            = state_q;
  assign sym_cnt_o          = cnt_q;
  assign clamp_o            = clamp_q;

endmodule

// File: tb/tb_sym_timing_nco_ctrl.sv
// Self-checking bench for sym_timing_nco_ctrl: directed scenarios with
// closed-form strobe timing, plus randomized stimulus against a cycle model.
`timescale 1ns/1ps
module tb_sym_timing_nco_ctrl;
  import msk_timing_pkg::*;

  localparam longint MM  = longint'(M_VAL);
  localparam longint ONE = longint'(1) << MU_W;
  localparam longint ADJ = longint'(MAX_ADJ);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable_i;
  logic             restart_i;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] sym_cnt_o;
  logic             clamp_o;

  sym_timing_nco_ctrl_if interp_if ();

  sym_timing_nco_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable_i  (enable_i),
    .restart_i (restart_i),
    .interp    (interp_if),
    .state_o   (state_o),
    .sym_cnt_o (sym_cnt_o),
    .clamp_o   (clamp_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase tracked as a plain integer modulo M.
  int     m_state = 0;
  longint m_acc = 0, m_ctrl = 0, m_phase = 0, m_mu = 0;
  int     m_fill = 0, m_cnt = 0;
  bit     m_valid = 0, m_clamp = 0;

  function automatic longint sat(input longint v);
    if (v > ADJ) return ADJ;
    if (v < -ADJ) return -ADJ;
    return v;
  endfunction

  task automatic model_step();
    longint c_in = longint'(interp_if.ctrl_i);
    longint s;
    bit over;
    if (!reset_n) begin
      m_state = 0; m_acc = 0; m_ctrl = 0; m_phase = 0; m_mu = 0;
      m_fill = 0; m_cnt = 0; m_valid = 0; m_clamp = 0;
      return;
    end
    over    = interp_if.ctrl_valid_i && (c_in > ADJ || c_in < -ADJ);
    m_clamp = ((m_state == 0) ? 1'b0 : m_clamp) | over;
    s       = m_acc + ONE + sat(m_ctrl);
    if (interp_if.ctrl_valid_i) m_ctrl = c_in;
    m_valid = 0;
    if (!enable_i) begin
      m_state = 0; m_acc = 0; m_fill = 0; m_cnt = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_acc = 0; m_fill = 0;
    end else if (m_state == 1) begin
      if (m_fill == FILL_LEN - 1) begin
        m_state = 2; m_acc = 0; m_fill = 0; m_cnt = 0;
      end else begin
        m_fill++;
      end
    end else begin
      if (restart_i) m_acc = 0;
      else if (s >= MM) begin
        m_acc   = s - MM;
        m_valid = 1;
        m_phase = m_acc / ONE;
        m_mu    = m_acc % ONE;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      end else m_acc = s;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("m_state", state_o, m_state);
    chk("m_valid", interp_if.sym_valid_o, m_valid);
    chk("m_phase", interp_if.phase_int_o, m_phase);
    chk("m_mu", interp_if.mu_o, m_mu);
    chk("m_cnt", sym_cnt_o, m_cnt);
    chk("m_clamp", clamp_o, m_clamp);
  endtask

  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!interp_if.sym_valid_o && n < limit);
    if (!interp_if.sym_valid_o) chk("strobe_timeout", interp_if.sym_valid_o, 1);
  endtask

  task automatic measure_fill(input string tag);
    int n = 0;
    while (state_o == 2'd1 && n < 300) begin
      n++;
      tick();
    end
    chk(tag, n, FILL_LEN);
    chk({tag, "_run"}, state_o, 2);
  endtask

  // Strobe k after an accumulator zero with constant increment d lands on
  // clock ceil(k*M/d) with residue n*d - k*M.
  task automatic closed_form(input string tag, input longint k, input longint t, input longint d);
    longint n_exp = (k * MM + d - 1) / d;
    longint r     = n_exp * d - k * MM;
    chk({tag, "_time"}, t, n_exp);
    chk({tag, "_phase"}, interp_if.phase_int_o, r / ONE);
    chk({tag, "_mu"}, interp_if.mu_o, r % ONE);
  endtask

  task automatic set_ctrl(input int v);
    interp_if.ctrl_i       = ctrl_t'(v);
    interp_if.ctrl_valid_i = 1'b1;
    tick();
    interp_if.ctrl_valid_i = 1'b0;
  endtask

  initial begin
    int n;
    longint t;
    int v;

    reset_n = 1'b0; enable_i = 1'b0; restart_i = 1'b0;
    interp_if.ctrl_i = '0; interp_if.ctrl_valid_i = 1'b0;

    // 1: reset values, FILL length, nominal strobe spacing
    repeat (3) tick();
    chk("rst_state", state_o, 0);
    chk("rst_valid", interp_if.sym_valid_o, 0);
    chk("rst_phase", interp_if.phase_int_o, 0);
    chk("rst_mu", interp_if.mu_o, 0);
    chk("rst_cnt", sym_cnt_o, 0);
    chk("rst_clamp", clamp_o, 0);
    reset_n = 1'b1; enable_i = 1'b1;
    tick();
    chk("t1_fill_entry", state_o, 1);
    measure_fill("t1_fill_len");
    wait_strobe(100, n);
    chk("t1_first", n, 20);
    chk("t1_phase", interp_if.phase_int_o, 0);
    chk("t1_mu", interp_if.mu_o, 0);
    for (int i = 0; i < 4; i++) begin
      wait_strobe(100, n);
      chk("t1_interval", n, 20);
    end
    chk("t1_cnt", sym_cnt_o, 5);

    // 2: +2^20 correction applied before enable, 1000 symbols
    reset_n = 1'b0; enable_i = 1'b0;
    tick();
    reset_n = 1'b1;
    set_ctrl(MAX_ADJ);
    enable_i = 1'b1;
    tick();
    chk("t2_fill_entry", state_o, 1);
    measure_fill("t2_fill_len");
    t = 0;
    for (int k = 1; k <= 1000; k++) begin
      wait_strobe(40, n);
      t += n;
      closed_form("t2", k, t, ONE + ADJ);
    end
    chk("t2_cnt", sym_cnt_o, 1000);
    chk("t2_clamp", clamp_o, 0);

    // 3: oversized corrections saturate and set the sticky flag
    set_ctrl(2**22);
    chk("t3_clamp_pos", clamp_o, 1);
    restart_i = 1'b1; tick(); restart_i = 1'b0;
    wait_strobe(40, n);
    closed_form("t3_pos", 1, n, ONE + ADJ);
    set_ctrl(-(2**22));
    chk("t3_clamp_neg", clamp_o, 1);
    restart_i = 1'b1; tick(); restart_i = 1'b0;
    t = 0;
    for (int k = 1; k <= 2; k++) begin
      wait_strobe(40, n);
      t += n;
      closed_form("t3_neg", k, t, ONE - ADJ);
    end
    chk("t3_clamp_hold", clamp_o, 1);

    // 4: disable mid-RUN, clamp clears in IDLE, full FILL on re-enable
    enable_i = 1'b0;
    tick();
    chk("t4_state", state_o, 0);
    chk("t4_valid", interp_if.sym_valid_o, 0);
    chk("t4_cnt", sym_cnt_o, 0);
    chk("t4_clamp_kept", clamp_o, 1);
    tick();
    chk("t4_clamp_clr", clamp_o, 0);
    set_ctrl(0);
    enable_i = 1'b1;
    tick();
    chk("t4_fill_entry", state_o, 1);
    measure_fill("t4_fill_len");

    // 5: restart on the wrap clock suppresses that strobe
    wait_strobe(40, n);
    chk("t5_first", n, 20);
    repeat (19) tick();
    restart_i = 1'b1;
    tick();
    chk("t5_suppressed", interp_if.sym_valid_o, 0);
    restart_i = 1'b0;
    wait_strobe(40, n);
    chk("t5_next", n, 20);
    chk("t5_mu", interp_if.mu_o, 0);

    // 6: reset mid-RUN with a simultaneous ctrl capture
    set_ctrl(1000);
    restart_i = 1'b1; tick(); restart_i = 1'b0;
    wait_strobe(40, n);
    closed_form("t6_pre", 1, n, ONE + 1000);
    repeat (7) tick();
    reset_n = 1'b0;
    interp_if.ctrl_i = ctrl_t'(12345);
    interp_if.ctrl_valid_i = 1'b1;
    tick();
    reset_n = 1'b1;
    interp_if.ctrl_valid_i = 1'b0;
    chk("t6_state", state_o, 0);
    chk("t6_valid", interp_if.sym_valid_o, 0);
    chk("t6_phase", interp_if.phase_int_o, 0);
    chk("t6_mu", interp_if.mu_o, 0);
    chk("t6_cnt", sym_cnt_o, 0);
    chk("t6_clamp", clamp_o, 0);
    tick();
    chk("t6_fill_entry", state_o, 1);
    measure_fill("t6_fill_len");
    wait_strobe(40, n);
    chk("t6_first", n, 20);
    chk("t6_mu_zero", interp_if.mu_o, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 5000; i++) begin
      reset_n   = ($urandom_range(0, 999) != 0);
      enable_i  = ($urandom_range(0, 299) != 0);
      restart_i = ($urandom_range(0, 39) == 0);
      interp_if.ctrl_valid_i = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 5))
        0, 1:    v = int'($urandom_range(0, 2 * MAX_ADJ)) - MAX_ADJ;
        2:       v = MAX_ADJ;
        3:       v = -MAX_ADJ;
        4:       v = ($urandom_range(0, 1) != 0) ? MAX_ADJ + 1 : -(MAX_ADJ + 1);
        default: v = int'($urandom);
      endcase
      interp_if.ctrl_i = ctrl_t'(v);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
